// File: rtl/lock_chamber_ctrl.sv
// Chamber-side lock controller: validates operator commands against gate/water interlocks and sequences gates, level and gondola moves.
// Optional LOCK_AUTOCLOSE_EN: after a completed EXIT, automatically close the open gate before reporting done.
module lock_chamber_ctrl #(
  parameter int LEVEL_MAX  = 7,
  parameter int LW         = 3,
  parameter int STEP_TICKS = 4,
  parameter int GATE_TICKS = 2,
  parameter int MOVE_TICKS = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd_code,
  output logic          cmd_ready,
  input  logic          arrive_L,
  input  logic          arrive_R,
  output logic          done,
  output logic          err,
  output logic [LW-1:0] level,
  output logic          gateL_open,
  output logic          gateR_open,
  output logic          gond_L,
  output logic          gond_ch,
  output logic          gond_R
);

  localparam int TMAX_GS = (GATE_TICKS > STEP_TICKS) ? GATE_TICKS : STEP_TICKS;
  localparam int TMAX    = (MOVE_TICKS > TMAX_GS) ? MOVE_TICKS : TMAX_GS;
  localparam int TW      = $clog2(TMAX + 1);

  localparam logic [TW-1:0] GATE_LOAD = TW'(GATE_TICKS - 1);
  localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_TICKS - 1);
  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_TICKS - 1);
  localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  localparam logic [LW-1:0] LVL_TOP     = LW'(LEVEL_MAX);
  localparam logic [LW-1:0] LVL_PRE_TOP = LW'(LEVEL_MAX - 1);
  localparam logic [LW-1:0] LVL_ZERO    = LW'(0);
  localparam logic [LW-1:0] LVL_ONE     = LW'(1);

  localparam logic [2:0] CMD_NOP    = 3'd0;
  localparam logic [2:0] CMD_OPEN_L = 3'd1;
  localparam logic [2:0] CMD_OPEN_R = 3'd2;
  localparam logic [2:0] CMD_CLOSE  = 3'd3;
  localparam logic [2:0] CMD_FILL   = 3'd4;
  localparam logic [2:0] CMD_DRAIN  = 3'd5;
  localparam logic [2:0] CMD_ENTER  = 3'd6;
  localparam logic [2:0] CMD_EXIT   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GATE  = 3'd1,
    ST_FILL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_MOVE  = 3'd4
  } state_t;

  state_t        state_r, state_n;
  logic [TW-1:0] timer_r, timer_n;
  logic [2:0]    op_r, op_n;
  logic [LW-1:0] level_r, level_n;
  logic          gate_lft_r, gate_lft_n;
  logic          gate_rgt_r, gate_rgt_n;
  logic          pos_lft_r, pos_lft_n;
  logic          pos_ch_r, pos_ch_n;
  logic          pos_rgt_r, pos_rgt_n;
  logic          done_r, done_n;
  logic          err_r, err_n;
  logic          ready_r, ready_n;

  logic any_pos_s;
  logic gates_shut_s;
  logic enter_ok_s;
  logic exit_ok_s;

  assign any_pos_s    = pos_lft_r | pos_ch_r | pos_rgt_r;
  assign gates_shut_s = ~(gate_lft_r | gate_rgt_r);
  assign enter_ok_s   = (pos_lft_r & gate_lft_r) | (pos_rgt_r & gate_rgt_r);
  assign exit_ok_s    = pos_ch_r & ~gates_shut_s;

  // Next-state, datapath and response decode
  always_comb begin
    state_n    = state_r;
    timer_n    = timer_r;
    op_n       = op_r;
    level_n    = level_r;
    gate_lft_n = gate_lft_r;
    gate_rgt_n = gate_rgt_r;
    pos_lft_n  = pos_lft_r;
    pos_ch_n   = pos_ch_r;
    pos_rgt_n  = pos_rgt_r;
    done_n     = 1'b0;
    err_n      = 1'b0;

    // Arrivals are only registered while the lock holds no gondola; left wins a tie.
    if (!any_pos_s && arrive_L) begin
      pos_lft_n = 1'b1;
    end else if (!any_pos_s && arrive_R) begin
      pos_rgt_n = 1'b1;
    end else begin
      pos_lft_n = pos_lft_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_n = cmd_code;
          case (cmd_code)
            CMD_NOP: done_n = 1'b1;
            CMD_OPEN_L: begin
              if ((level_r != LVL_ZERO) || gate_rgt_r) begin
                err_n = 1'b1;
              end else if (gate_lft_r) begin
                done_n = 1'b1;
              end else begin
                state_n = ST_GATE;
                timer_n = GATE_LOAD;
              end
            end
            CMD_OPEN_R: begin
              if ((level_r != LVL_TOP) || gate_lft_r) begin
                err_n = 1'b1;
              end else if (gate_rgt_r) begin
                done_n = 1'b1;
              end else begin
                state_n = ST_GATE;
                timer_n = GATE_LOAD;
              end
            end
            CMD_CLOSE: begin
              if (gates_shut_s) begin
                done_n = 1'b1;
              end else begin
                state_n = ST_GATE;
                timer_n = GATE_LOAD;
              end
            end
            CMD_FILL: begin
              if (!gates_shut_s) begin
                err_n = 1'b1;
              end else if (level_r == LVL_TOP) begin
                done_n = 1'b1;
              end else begin
                state_n = ST_FILL;
                timer_n = STEP_LOAD;
              end
            end
            CMD_DRAIN: begin
              if (!gates_shut_s) begin
                err_n = 1'b1;
              end else if (level_r == LVL_ZERO) begin
                done_n = 1'b1;
              end else begin
                state_n = ST_DRAIN;
                timer_n = STEP_LOAD;
              end
            end
            CMD_ENTER: begin
              if (enter_ok_s) begin
                state_n = ST_MOVE;
                timer_n = MOVE_LOAD;
              end else begin
                err_n = 1'b1;
              end
            end
            CMD_EXIT: begin
              if (exit_ok_s) begin
                state_n = ST_MOVE;
                timer_n = MOVE_LOAD;
              end else begin
                err_n = 1'b1;
              end
            end
            default: done_n = 1'b1;
          endcase
        end else begin
          op_n = op_r;
        end
      end

      ST_GATE: begin
        if (timer_r == TIMER_ZERO) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
          case (op_r)
            CMD_OPEN_L: gate_lft_n = 1'b1;
            CMD_OPEN_R: gate_rgt_n = 1'b1;
            default: begin
              gate_lft_n = 1'b0;
              gate_rgt_n = 1'b0;
            end
          endcase
        end else begin
          timer_n = timer_r - TIMER_ONE;
        end
      end

      ST_FILL: begin
        if (timer_r == TIMER_ZERO) begin
          level_n = level_r + LVL_ONE;
          timer_n = STEP_LOAD;
          if (level_r == LVL_PRE_TOP) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_FILL;
          end
        end else begin
          timer_n = timer_r - TIMER_ONE;
        end
      end

      ST_DRAIN: begin
        if (timer_r == TIMER_ZERO) begin
          level_n = level_r - LVL_ONE;
          timer_n = STEP_LOAD;
          if (level_r == LVL_ONE) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_DRAIN;
          end
        end else begin
          timer_n = timer_r - TIMER_ONE;
        end
      end

      ST_MOVE: begin
        if (timer_r == TIMER_ZERO) begin
          pos_lft_n = 1'b0;
          pos_rgt_n = 1'b0;
          if (op_r == CMD_ENTER) begin
            pos_ch_n = 1'b1;
            state_n  = ST_IDLE;
            done_n   = 1'b1;
          end else begin
            pos_ch_n = 1'b0;
`ifdef LOCK_AUTOCLOSE_EN
            // The gondola has left; reuse the gate sequencer to shut the gate behind it.
            op_n    = CMD_CLOSE;
            state_n = ST_GATE;
            timer_n = GATE_LOAD;
`else
            state_n = ST_IDLE;
            done_n  = 1'b1;
`endif
          end
        end else begin
          timer_n = timer_r - TIMER_ONE;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    ready_n = (state_n == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      timer_r    <= TIMER_ZERO;
      op_r       <= CMD_NOP;
      level_r    <= LVL_ZERO;
      gate_lft_r <= 1'b0;
      gate_rgt_r <= 1'b0;
      pos_lft_r  <= 1'b0;
      pos_ch_r   <= 1'b0;
      pos_rgt_r  <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      state_r    <= state_n;
      timer_r    <= timer_n;
      op_r       <= op_n;
      level_r    <= level_n;
      gate_lft_r <= gate_lft_n;
      gate_rgt_r <= gate_rgt_n;
      pos_lft_r  <= pos_lft_n;
      pos_ch_r   <= pos_ch_n;
      pos_rgt_r  <= pos_rgt_n;
      done_r     <= done_n;
      err_r      <= err_n;
      ready_r    <= ready_n;
    end
  end

  assign cmd_ready  = ready_r;
  assign done       = done_r;
  assign err        = err_r;
  assign level      = level_r;
  assign gateL_open = gate_lft_r;
  assign gateR_open = gate_rgt_r;
  assign gond_L     = pos_lft_r;
  assign gond_ch    = pos_ch_r;
  assign gond_R     = pos_rgt_r;

endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// Scoreboard bench for lock_chamber_ctrl: a rule-level lock model predicts each command's outcome; a monitor checks every done/err pulse.
module tb_lock_chamber_ctrl;

  localparam int LEVEL_MAX  = 7;
  localparam int LW         = 3;
  localparam int STEP_TICKS = 4;
  localparam int GATE_TICKS = 2;
  localparam int MOVE_TICKS = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_code = 3'd0;
  logic          cmd_ready;
  logic          arrive_L = 1'b0;
  logic          arrive_R = 1'b0;
  logic          done;
  logic          err;
  logic [LW-1:0] level;
  logic          gateL_open;
  logic          gateR_open;
  logic          gond_L;
  logic          gond_ch;
  logic          gond_R;

  lock_chamber_ctrl #(
    .LEVEL_MAX(LEVEL_MAX), .LW(LW), .STEP_TICKS(STEP_TICKS),
    .GATE_TICKS(GATE_TICKS), .MOVE_TICKS(MOVE_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ready(cmd_ready), .arrive_L(arrive_L), .arrive_R(arrive_R),
    .done(done), .err(err), .level(level), .gateL_open(gateL_open),
    .gateR_open(gateR_open), .gond_L(gond_L), .gond_ch(gond_ch), .gond_R(gond_R)
  );

  always #5 clk = ~clk;

  // Position: 0 none, 1 waiting left, 2 in chamber, 3 waiting right
  typedef struct {
    logic is_err;
    int   lat;
    int   lvl;
    logic gl;
    logic gr;
    int   pos;
    int   start;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   cur_start = 0;
  int   prev_lvl = 0;

  int   m_lvl = 0;
  logic m_gl = 1'b0;
  logic m_gr = 1'b0;
  int   m_pos = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int pos_code(input logic l, input logic c, input logic r);
    if (l && !c && !r) return 1;
    else if (!l && c && !r) return 2;
    else if (!l && !c && r) return 3;
    else if (!l && !c && !r) return 0;
    else return 9;
  endfunction

  // Lock rules applied to the model; returns the predicted response
  task automatic model_cmd(input logic [2:0] code, output exp_t e);
    e.is_err = 1'b0;
    e.lat    = 0;
    case (code)
      3'd1: if (m_lvl != 0 || m_gr) e.is_err = 1'b1;
            else if (!m_gl) begin m_gl = 1'b1; e.lat = GATE_TICKS; end
      3'd2: if (m_lvl != LEVEL_MAX || m_gl) e.is_err = 1'b1;
            else if (!m_gr) begin m_gr = 1'b1; e.lat = GATE_TICKS; end
      3'd3: if (m_gl || m_gr) begin m_gl = 1'b0; m_gr = 1'b0; e.lat = GATE_TICKS; end
      3'd4: if (m_gl || m_gr) e.is_err = 1'b1;
            else begin e.lat = STEP_TICKS * (LEVEL_MAX - m_lvl); m_lvl = LEVEL_MAX; end
      3'd5: if (m_gl || m_gr) e.is_err = 1'b1;
            else begin e.lat = STEP_TICKS * m_lvl; m_lvl = 0; end
      3'd6: if ((m_pos == 1 && m_gl) || (m_pos == 3 && m_gr)) begin m_pos = 2; e.lat = MOVE_TICKS; end
            else e.is_err = 1'b1;
      3'd7: if (m_pos == 2 && (m_gl || m_gr)) begin
              m_pos = 0;
              e.lat = MOVE_TICKS;
`ifdef LOCK_AUTOCLOSE_EN
              m_gl = 1'b0;
              m_gr = 1'b0;
              e.lat = MOVE_TICKS + GATE_TICKS;
`endif
            end else e.is_err = 1'b1;
      default: e.lat = 0;
    endcase
    e.lvl = m_lvl;
    e.gl  = m_gl;
    e.gr  = m_gr;
    e.pos = m_pos;
  endtask

  task automatic issue(input logic [2:0] code);
    exp_t e;
    int t;
    @(negedge clk);
    model_cmd(code, e);
    e.start   = cyc + 1;
    cur_start = e.start;
    exp_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_code  = code;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("response_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic arrive(input logic l, input logic r);
    @(negedge clk);
    arrive_L = l;
    arrive_R = r;
    if (m_pos == 0 && l) m_pos = 1;
    else if (m_pos == 0 && r) m_pos = 3;
    @(negedge clk);
    arrive_L = 1'b0;
    arrive_R = 1'b0;
    chk("arrive_pos", pos_code(gond_L, gond_ch, gond_R), m_pos);
  endtask

  // Response monitor: every done/err pulse must match the oldest prediction
  always @(negedge clk) begin
    if (reset) begin
      if (done && err) chk("done_err_exclusive", 1, 0);
      if (done || err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_is_err", int'(err), int'(mon_e.is_err));
          chk("resp_latency", cyc - mon_e.start, mon_e.lat);
          chk("resp_level", int'(level), mon_e.lvl);
          chk("resp_gateL", int'(gateL_open), int'(mon_e.gl));
          chk("resp_gateR", int'(gateR_open), int'(mon_e.gr));
          chk("resp_pos", pos_code(gond_L, gond_ch, gond_R), mon_e.pos);
          chk("resp_ready", int'(cmd_ready), 1);
          chk("gates_exclusive", int'(gateL_open && gateR_open), 0);
        end
      end
    end
  end

  // Level watcher: single-unit steps, only on STEP_TICKS boundaries of the current command
  always @(negedge clk) begin
    if (!reset) begin
      prev_lvl = 0;
    end else if (int'(level) != prev_lvl) begin
      chk("level_step_size", (int'(level) > prev_lvl) ? int'(level) - prev_lvl : prev_lvl - int'(level), 1);
      chk("level_step_time", (cyc - cur_start) % STEP_TICKS, 0);
      prev_lvl = int'(level);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_gates", int'({gateL_open, gateR_open}), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_pos", pos_code(gond_L, gond_ch, gond_R), 0);

    // Directed walk through a full up-lock
    arrive(1'b1, 1'b0);
    issue(3'd1);
    issue(3'd6);
    issue(3'd3);
    issue(3'd4);
    issue(3'd2);
    issue(3'd1);
    issue(3'd4);
    issue(3'd6);
    issue(3'd7);
    issue(3'd3);
    arrive(1'b1, 1'b1);
    arrive(1'b0, 1'b1);
    issue(3'd0);
    issue(3'd5);

    for (int i = 0; i < 90; i++) begin
      if ($urandom_range(0, 2) == 0) arrive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      issue(3'($urandom_range(0, 7)));
    end

    // Reset in the middle of a drain from the top level
    issue(3'd3);
    issue(3'd4);
    @(negedge clk);
    cur_start = cyc + 1;
    cmd_valid = 1'b1;
    cmd_code  = 3'd5;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    t = 0;
    while (cyc != cur_start + 3 * STEP_TICKS && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("middrain_level", int'(level), LEVEL_MAX - 3);
    reset = 1'b0;
    #1;
    chk("rst_mid_level", int'(level), 0);
    chk("rst_mid_outs", int'({done, err, gateL_open, gateR_open, gond_L, gond_ch, gond_R}), 0);
    exp_q.delete();
    m_lvl = 0; m_gl = 1'b0; m_gr = 1'b0; m_pos = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(cmd_ready), 1);
    chk("post_rst_level", int'(level), 0);
    repeat (40) @(negedge clk);
    chk("post_rst_idle_level", int'(level), 0);
    issue(3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lock_chamber_ctrl.md
# lock_chamber_ctrl

Chamber-side responder for the pound lock system. Accepts one operator command at a time over a valid/ready handshake, enforces the gate/water interlocks, and sequences gates, water level and gondola position with fixed per-action durations. Completion or refusal of each command is reported with a one-cycle pulse. The operator-input front end drives the command side; the status outputs drive the LEDR/HEX displays.

## Interface
Parameters:
- LEVEL_MAX, 7: upstream (right-side) water level; downstream (left) level is 0.
- LW, 3: width of `level`; must satisfy LEVEL_MAX < 2**LW.
- STEP_TICKS, 4: cycles per one-unit level change.
- GATE_TICKS, 2: cycles to open or close a gate.
- MOVE_TICKS, 3: cycles for the gondola to enter or exit the chamber.

Ports:
- clk  in  1  system clock (one clock domain).
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  a command is presented.
- cmd_code  in  3  0 NOP, 1 OPEN_L, 2 OPEN_R, 3 CLOSE, 4 FILL, 5 DRAIN, 6 ENTER, 7 EXIT.
- cmd_ready  out  1  block is idle and accepts a command.
- arrive_L, arrive_R  in  1  gondola sensed waiting outside the left/right gate.
- done  out  1  one-cycle pulse: accepted command completed.
- err  out  1  one-cycle pulse: accepted command refused by interlock.
- level  out  LW  current chamber water level.
- gateL_open, gateR_open  out  1  gate state.
- gond_L, gond_ch, gond_R  out  1  gondola waiting left / in chamber / waiting right (one-hot or all 0).

## Operation
- FSM states: IDLE, GATE, FILL, DRAIN, MOVE. cmd_ready = (state == IDLE).
- Accept on a cycle with cmd_valid && cmd_ready; code is latched and checked in that cycle.
- Interlocks (refusal -> err pulse, state stays IDLE, nothing changes):
  - OPEN_L: level == 0 and gateR closed. OPEN_R: level == LEVEL_MAX and gateL closed.
  - FILL, DRAIN: both gates closed.
  - ENTER: (gond_L and gateL_open) or (gond_R and gateR_open).
  - EXIT: gond_ch and a gate is open.
- NOP, CLOSE with both gates closed, OPEN of an already-open gate, FILL at LEVEL_MAX, DRAIN at 0: accepted, done pulses next cycle, no change.
- GATE: timer GATE_TICKS, then gate output updates. CLOSE closes whichever gate is open.
- FILL/DRAIN: level ±1 every STEP_TICKS cycles until LEVEL_MAX / 0; never wraps.
- MOVE: after MOVE_TICKS, ENTER sets gond_ch (clears gond_L/gond_R); EXIT clears all position bits (gondola departs through the open gate).
- Position register: when all position bits are 0, arrive_L sets gond_L, else arrive_R sets gond_R; both high same cycle -> left wins. Arrivals ignored while any position bit set.
- Both gates never open simultaneously (invariant).

## Timing
- Accept at edge N. Refusal or no-op: done/err high for cycle N..N+1 only, cmd_ready stays high.
- GATE: gate output and done change at edge N+GATE_TICKS; cmd_ready returns high the same edge.
- FILL from level k: level increments at N+STEP_TICKS·i; done with final value at N+STEP_TICKS·(LEVEL_MAX−k). DRAIN symmetric.
- MOVE: position bits and done at N+MOVE_TICKS.
- done and err never both high; at most one pulse per accepted command.
- Reset (any time, including mid-FILL): all outputs immediately 0 except cmd_ready = 1 after deassertion; level 0, gates closed, position cleared, timers cleared.
- arrive_* sampled every cycle regardless of FSM state.

## Configuration
- LOCK_AUTOCLOSE_EN defined: after an accepted EXIT completes its MOVE, the FSM enters GATE and closes the open gate; the single done pulses at N+MOVE_TICKS+GATE_TICKS with the gate already closed.
- Undefined: EXIT completes at N+MOVE_TICKS with the gate left open; CLOSE must be issued explicitly.

## Test plan
- Reset, arrive_L pulse, OPEN_L -> gateL_open=1 and done at +2; ENTER -> gond_ch=1, gond_L=0, done at +3.
- CLOSE, FILL from 0 -> level steps 1..7 every 4 cycles, done with level=7 at +28; OPEN_R -> gateR_open=1 at +2.
- Interlocks: OPEN_L at level 7 -> err at +1, no change; FILL with gateR open -> err; ENTER with no gondola -> err.
- EXIT with gateR open -> position cleared at +3; macro defined: gateR_open=0 and done at +5; undefined: gate stays open, done at +3.
- Simultaneous arrive_L and arrive_R with no gondola -> gond_L=1 only; later arrive_R ignored.
- Reset asserted mid-DRAIN (level 4) -> level=0, gates closed, cmd_ready=1 after release, no done pulse.
